// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch types and constants.
package legv8_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Small synchronous FIFO with flush; used for fetched words and in-flight PCs.
module fetch_fifo
    import legv8_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  T                             din,
    input  logic                         pop,
    input  logic                         flush,
    output T                             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    T              mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && (count != CW'(DEPTH));
    assign dout    = mem[rptr];

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= din;
                wptr      <= nxt(wptr);
            end
            if (pop_ok) rptr <= nxt(rptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// LEGv8 instruction fetch: PC, credit-limited imem requests,
// response buffering and branch redirect with stale-response draining.
module ifetch_unit
    import legv8_pkg::*;
#(
    parameter int             N        = 64,
    parameter logic [N-1:0]   PC_RESET = '0,
    parameter int             DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_o,
    output logic [N-1:0]       imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [31:0]        imem_rdata_i,
    output logic               instr_valid_o,
    output logic [31:0]        instr_o,
    output logic [N-1:0]       instr_pc_o,
    input  logic               instr_ready_i,
    input  logic               PCSrc_i,
    input  logic [N-1:0]       PCBranch_i
);

    localparam int FCW = $clog2(DEPTH+1);
    // Drained responses stay outstanding, so headroom beyond DEPTH is needed.
    localparam int CW  = FCW + 2;
    localparam int UW  = CW + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [N-1:0]       pc;
    } entry_t;

    logic [N-1:0]   pc_q;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drain_cnt;
    entry_t         last_q;

    entry_t         head;
    entry_t         push_ent;
    logic [FCW-1:0] fcount;
    logic [N-1:0]   aq_head;
    logic [FCW-1:0] aq_count;

    logic           rv_ok;
    logic           draining;
    logic           credit;
    logic [UW-1:0]  used;
    logic           req_hs;
    logic           push;
    logic           pop;
    logic           unused_bits;

    assign rv_ok    = imem_rvalid_i && (outstanding != '0);
    assign draining = (drain_cnt != '0);
    assign used     = UW'(fcount) + UW'(outstanding) - UW'(drain_cnt);
    assign credit   = (used < UW'(DEPTH)) && (outstanding != '1);

    assign imem_req_o    = !reset && !PCSrc_i && credit;
    assign imem_addr_o   = pc_q;
    assign req_hs        = imem_req_o && imem_gnt_i;

    assign push          = rv_ok && !draining && !PCSrc_i;
    assign instr_valid_o = !PCSrc_i && (fcount != '0);
    assign pop           = instr_valid_o && instr_ready_i;

    assign push_ent.instr = imem_rdata_i;
    assign push_ent.pc    = aq_head;

    assign instr_o     = (fcount != '0) ? head.instr : last_q.instr;
    assign instr_pc_o  = (fcount != '0) ? head.pc    : last_q.pc;
    assign unused_bits = ^{PCBranch_i[1:0], aq_count};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_ifq (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .flush (PCSrc_i),
        .dout  (head),
        .count (fcount)
    );

    // In-order PCs of live (non-drained) requests.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [N-1:0])
    ) u_aq (
        .clk   (clk),
        .reset (reset),
        .push  (req_hs),
        .din   (pc_q),
        .pop   (push),
        .flush (PCSrc_i),
        .dout  (aq_head),
        .count (aq_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= PC_RESET;
            outstanding <= '0;
            drain_cnt   <= '0;
            last_q      <= '0;
        end else begin
            if (fcount != '0) last_q <= head;
            outstanding <= outstanding + CW'(req_hs) - CW'(rv_ok);
            if (PCSrc_i) begin
                pc_q      <= {PCBranch_i[N-1:2], 2'b00};
                drain_cnt <= outstanding - CW'(rv_ok);
            end else begin
                if (req_hs) pc_q <= pc_q + N'(PC_STEP);
                if (rv_ok && draining) drain_cnt <= drain_cnt - CW'(1);
            end
        end
    end

    a_rvalid_outstanding: assert property (
        @(posedge clk) disable iff (reset)
        imem_rvalid_i |-> (outstanding != '0)
    );

endmodule
